xprog_dma: RTL and testbench
============================

Name: xprog_dma

Overview:
- DMA initiator for the program memory's DMA port: the engine that drives dma_sel/dma_we/dma_addr/dma_data_in and consumes dma_data_out.
- Load mode: moves words from an inbound valid/ready stream into program memory (program loading).
- Dump mode: reads program memory and presents the words on an outbound valid/ready stream.
- Yields to controller data-port accesses, which have priority at the memory.

Parameters:
- DATA_W, 32, memory word width (matches `DATA_W).
- ADDR_W, 10, program memory address width (matches `PROG_ADDR_W).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle transfer request, sampled only in IDLE
- dir  in  1  0 = load (stream to RAM), 1 = dump (RAM to stream); sampled with start
- base_addr  in  ADDR_W  first word address; sampled with start
- len  in  ADDR_W+1  word count, 0..2^ADDR_W; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- s_valid  in  1  inbound word valid
- s_data  in  DATA_W  inbound word
- s_ready  out  1  inbound word accepted when s_valid & s_ready
- m_valid  out  1  outbound word valid
- m_data  out  DATA_W  outbound word
- m_ready  in  1  outbound sink ready
- ctrl_sel  in  1  controller data-port select; when high, the memory ignores DMA this cycle
- dma_sel  out  1  memory DMA enable
- dma_we  out  1  memory DMA write enable
- dma_addr  out  ADDR_W  memory DMA address
- dma_data_in  out  DATA_W  memory write data
- dma_data_out  in  DATA_W  memory read data, valid one cycle after a read enable

Behaviour:
- Reset (async) puts the FSM in IDLE. All of these are 0: busy, done, s_ready, m_valid, m_data, dma_sel, dma_we, dma_addr, dma_data_in, the address register and the remaining-count register.
- Registers: addr (ADDR_W), rem (ADDR_W+1), rdata (DATA_W).

IDLE:
- On start with len != 0: addr <= base_addr, rem <= len, next state LOAD (dir=0) or RD (dir=1).
- On start with len == 0: go to FIN. No memory access and no stream activity.
- start outside IDLE is ignored.

LOAD:
- s_ready = ~ctrl_sel (combinational).
- On s_valid & s_ready in the same cycle: dma_sel = dma_we = 1, dma_addr = addr, dma_data_in = s_data. Then addr <= addr+1 and rem <= rem-1.
- When rem reaches 0 on that transfer, go to FIN.
- Sustains 1 word/cycle when ctrl_sel stays low.
- dma_sel = 0 whenever no transfer occurs.

RD:
- If ~ctrl_sel: dma_sel = 1, dma_we = 0, dma_addr = addr, go to RW.
- If ctrl_sel: stay in RD with dma_sel = 0.

RW:
- rdata <= dma_data_out; addr <= addr+1; rem <= rem-1; go to OUT.

OUT:
- m_valid = 1, m_data = rdata.
- On m_ready: go to FIN if rem == 0, else go to RD.
- m_data is stable while m_valid & ~m_ready.

FIN:
- done = 1 for exactly one cycle, busy = 0, then return to IDLE.

General rules:
- busy = 1 in LOAD, RD, RW and OUT.
- Address arithmetic is modulo 2^ADDR_W: address 2^ADDR_W-1 wraps to 0.
- len = 2^ADDR_W covers the whole memory exactly once.
- The memory is never touched in IDLE or FIN.
- dma_we is asserted only in LOAD.
- ctrl_sel asserted while a write is pending: that word is not accepted (s_ready low) and nothing is lost.
- Reset mid-transfer aborts immediately with no done pulse. Memory words already written remain.
- Dump throughput is 1 word per 3 cycles minimum.

Test Plan:
- Load with ADDR_W=10, base_addr=0x3FE, len=4, words A0..A3 with s_valid held high and ctrl_sel=0 -> four write cycles to 0x3FE, 0x3FF, 0x000, 0x001; busy high 4 cycles; done pulses once on the following cycle; s_ready drops after the 4th word.
- Load len=3 with ctrl_sel=1 on the 2nd candidate cycle -> s_ready=0 and dma_sel=0 that cycle; the 2nd word is written the next cycle; memory holds exactly the 3 words at base..base+2.
- Dump base=0x010, len=2 (memory 0x010=0x11111111, 0x011=0x22222222), m_ready low for 3 cycles on the first word -> m_data=0x11111111 held stable; then 0x22222222; done after the 2nd handshake; dma_we never asserted.
- start with len=0 -> done pulses next cycle; dma_sel, s_ready and m_valid stay 0.
- start pulsed again mid-load with a different base_addr -> ignored; the original transfer completes unchanged.
- rst asserted after the 2nd of 4 load words -> all outputs 0 asynchronously; no done pulse; a new start afterwards runs normally from its own base_addr.

Source files
------------

// File: rtl/xprog_dma.sv
// DMA initiator for the program memory DMA port.
// Loads words from an inbound stream or dumps memory to an outbound stream.
module xprog_dma #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    input  logic              ctrl_sel,
    output logic              dma_sel,
    output logic              dma_we,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [DATA_W-1:0] dma_data_in,
    input  logic [DATA_W-1:0] dma_data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD,
        S_RW,
        S_OUT,
        S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   REM_ZERO = '0;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory-side outputs are gated to zero outside an actual access.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        rdata_d     = rdata_q;
        busy        = 1'b0;
        done        = 1'b0;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        dma_sel     = 1'b0;
        dma_we      = 1'b0;
        dma_addr    = '0;
        dma_data_in = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != REM_ZERO) begin
                        addr_d  = base_addr;
                        rem_d   = len;
                        state_d = dir ? S_RD : S_LOAD;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                s_ready = ~ctrl_sel;
                if (s_valid && !ctrl_sel) begin
                    dma_sel     = 1'b1;
                    dma_we      = 1'b1;
                    dma_addr    = addr_q;
                    dma_data_in = s_data;
                    addr_d      = addr_q + ADDR_ONE;
                    rem_d       = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RD: begin
                busy = 1'b1;
                if (!ctrl_sel) begin
                    dma_sel  = 1'b1;
                    dma_addr = addr_q;
                    state_d  = S_RW;
                end
            end
            S_RW: begin
                busy    = 1'b1;
                rdata_d = dma_data_out;
                addr_d  = addr_q + ADDR_ONE;
                rem_d   = rem_q - REM_ONE;
                state_d = S_OUT;
            end
            S_OUT: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_data  = rdata_q;
                if (m_ready) begin
                    state_d = (rem_q == REM_ZERO) ? S_FIN : S_RD;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_xprog_dma.sv
// Scoreboard bench for xprog_dma with a behavioural program memory.
// Expected writes and dumped words are queued by stimulus, popped by a monitor.
module tb_xprog_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic [9:0]  base_addr;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic        ctrl_sel;
    logic        dma_sel;
    logic        dma_we;
    logic [9:0]  dma_addr;
    logic [31:0] dma_data_in;
    logic [31:0] dma_data_out;

    logic [31:0] mem [1024];
    logic [41:0] wq [$];
    logic [31:0] oq [$];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int we_cnt = 0;

    xprog_dma #(.DATA_W(32), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir),
        .base_addr(base_addr), .len(len), .busy(busy), .done(done),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .ctrl_sel(ctrl_sel), .dma_sel(dma_sel), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_data_in(dma_data_in),
        .dma_data_out(dma_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dma_sel && !ctrl_sel) begin
            if (dma_we) mem[dma_addr] <= dma_data_in;
            dma_data_out <= mem[dma_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a transfer.
    always @(negedge clk) begin
        if (dma_sel && dma_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", {22'd0, dma_addr, dma_data_in}, 64'd0);
            end else begin
                chk("write", {22'd0, dma_addr, dma_data_in},
                    {22'd0, wq.pop_front()});
            end
        end
        if (m_valid && m_ready) begin
            if (oq.size() == 0) begin
                chk("unexpected_out", {32'd0, m_data}, 64'hdead);
            end else begin
                chk("out", {32'd0, m_data}, {32'd0, oq.pop_front()});
            end
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (dma_we) we_cnt++;
    end

    task automatic do_start(input logic d, input logic [9:0] b,
                            input logic [10:0] n);
        @(posedge clk); #1;
        start = 1'b1;
        dir = d;
        base_addr = b;
        len = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Feeds words w0+i; stops after 'stop' accepted words.
    task automatic do_load(input logic [9:0] base, input int n, input int stop,
                           input logic [31:0] w0, input int ctrl_k,
                           input int restart_k);
        int i;
        int k;
        logic acc;
        for (int j = 0; j < stop; j++) begin
            wq.push_back({base + 10'(j), w0 + 32'(j)});
        end
        do_start(1'b0, base, 11'(n));
        i = 0;
        k = 0;
        while (i < stop && k < 50) begin
            s_valid = 1'b1;
            s_data = w0 + 32'(i);
            ctrl_sel = (k == ctrl_k);
            if (k == restart_k) begin
                start = 1'b1;
                base_addr = base + 10'h100;
                len = 11'd1;
            end
            @(negedge clk);
            if (k == ctrl_k) begin
                chk("ctrl_s_ready", {63'd0, s_ready}, 64'd0);
                chk("ctrl_dma_sel", {63'd0, dma_sel}, 64'd0);
            end
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            start = 1'b0;
            ctrl_sel = 1'b0;
            if (acc) i++;
            k++;
        end
        if (i < stop) chk("load_timeout", 64'(i), 64'(stop));
        if (stop == n) s_valid = 1'b0;
    endtask

    task automatic expect_done_now();
        @(negedge clk);
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("fin_busy", {63'd0, busy}, 64'd0);
        chk("fin_s_ready", {63'd0, s_ready}, 64'd0);
        chk("fin_dma_sel", {63'd0, dma_sel}, 64'd0);
        @(negedge clk);
        chk("done_once", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int d0;
        int cyc;
        for (int a = 0; a < 1024; a++) mem[a] = 32'd0;
        mem[10'h010] = 32'h11111111;
        mem[10'h011] = 32'h22222222;
        rst = 1'b1;
        start = 1'b0;
        dir = 1'b0;
        base_addr = '0;
        len = '0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        ctrl_sel = 1'b0;
        #12;
        chk("rst_ctrl_outs", {58'd0, busy, done, s_ready, m_valid, dma_sel,
            dma_we}, 64'd0);
        chk("rst_data_outs", {dma_addr, m_data, 22'd0}, 64'd0);
        chk("rst_din", {32'd0, dma_data_in}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Load across the address wrap
        d0 = done_cnt;
        busy_cnt = 0;
        do_load(10'h3FE, 4, 4, 32'hA0000000, -1, -1);
        expect_done_now();
        chk("load_busy_cycles", 64'(busy_cnt), 64'd4);
        chk("load_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("mem_3fe", {32'd0, mem[10'h3FE]}, 64'hA0000000);
        chk("mem_001", {32'd0, mem[10'h001]}, 64'hA0000003);

        // Controller steals the second candidate cycle
        do_load(10'h100, 3, 3, 32'hB0000000, 1, -1);
        expect_done_now();
        chk("mem_101", {32'd0, mem[10'h101]}, 64'hB0000001);
        chk("mem_102", {32'd0, mem[10'h102]}, 64'hB0000002);
        chk("mem_103", {32'd0, mem[10'h103]}, 64'd0);

        // Restart attempt mid-load must be ignored
        d0 = done_cnt;
        do_load(10'h200, 4, 4, 32'hC0000000, -1, 1);
        expect_done_now();
        @(negedge clk);
        chk("restart_idle", {62'd0, busy, dma_sel}, 64'd0);
        chk("mem_203", {32'd0, mem[10'h203]}, 64'hC0000003);
        chk("mem_300", {32'd0, mem[10'h300]}, 64'd0);
        chk("restart_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Zero-length transfer
        @(posedge clk); #1;
        start = 1'b1;
        dir = 1'b0;
        base_addr = 10'h050;
        len = 11'd0;
        s_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("len0_done", {63'd0, done}, 64'd1);
        chk("len0_quiet", {61'd0, dma_sel, s_ready, m_valid}, 64'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("len0_done_once", {62'd0, done, busy}, 64'd0);

        // Dump with back-pressure on the first word
        we_cnt = 0;
        d0 = done_cnt;
        oq.push_back(32'h11111111);
        oq.push_back(32'h22222222);
        m_ready = 1'b0;
        do_start(1'b1, 10'h010, 11'd2);
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            if (m_valid) break;
            cyc++;
        end
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            chk("dump_hold_v", {63'd0, m_valid}, 64'd1);
            chk("dump_hold_d", {32'd0, m_data}, 64'h11111111);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            if (done) break;
            cyc++;
        end
        chk("dump_done_seen", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("dump_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("dump_no_we", 64'(we_cnt), 64'd0);
        chk("dump_oq_empty", 64'(oq.size()), 64'd0);

        // Reset after the second of four words
        d0 = done_cnt;
        do_load(10'h020, 4, 2, 32'hD0000000, -1, -1);
        rst = 1'b1;
        #1;
        chk("arst_ctrl", {58'd0, busy, done, s_ready, m_valid, dma_sel,
            dma_we}, 64'd0);
        chk("arst_bus", {dma_addr, dma_data_in, 22'd0}, 64'd0);
        s_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
        do_load(10'h040, 2, 2, 32'hE0000000, -1, -1);
        expect_done_now();
        chk("mem_021", {32'd0, mem[10'h021]}, 64'hD0000001);
        chk("mem_022", {32'd0, mem[10'h022]}, 64'd0);
        chk("mem_041", {32'd0, mem[10'h041]}, 64'hE0000001);
        chk("wq_empty", 64'(wq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
